// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared FSM states, PS/2 prefix codes and ASCII constants
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] ASCII_NONE  = 8'h00;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/ps2_ascii_rom.sv
// rtl/ps2_ascii_rom.sv - combinational set-2 scan code to ASCII table (PS2_SCAN_ASCII_EN only)
module ps2_ascii_rom
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_NONE;
        if (!ext) begin
            case (code)
                8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
                8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
                8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
                8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
                8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
                8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
                8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
                8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
                8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
                8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
                8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
                8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
                8'h46: ascii = 8'h39;
                8'h29: ascii = ASCII_SPACE;
                8'h5A: ascii = ASCII_CR;
                default: ascii = ASCII_NONE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// rtl/ps2_scan_ctrl.sv - PS/2 FIFO consumer and set-2 make/break decoder; PS2_SCAN_ASCII_EN adds ascii output
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               ready,
    input  logic [7:0]         data,
    input  logic               overflow,
    input  logic               clr_err,
    output logic               nextdata_n,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_held,
    output logic [COUNT_W-1:0] key_count,
    output logic               make_pulse,
    output logic               brk_pulse,
`ifdef PS2_SCAN_ASCII_EN
    output logic [7:0]         ascii,
`endif
    output logic               err_ovf
);

    ps2_state_t state, state_nx;
    logic       ext_pend, brk_pend;
    logic       take, same_key;

    assign take     = (state == IDLE) && ready;
    assign same_key = key_held && (data == key_code) && (ext_pend == key_ext);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ready) state_nx = POP;
            POP:     state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef PS2_SCAN_ASCII_EN
    logic [7:0] rom_ascii;

    ps2_ascii_rom u_rom (
        .code  (data),
        .ext   (ext_pend),
        .ascii (rom_ascii)
    );
`endif

    // Decode runs on the capture edge so key outputs lag ready by one edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            nextdata_n <= 1'b1;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_held   <= 1'b0;
            key_count  <= '0;
            make_pulse <= 1'b0;
            brk_pulse  <= 1'b0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
`ifdef PS2_SCAN_ASCII_EN
            ascii      <= ASCII_NONE;
`endif
        end else begin
            nextdata_n <= (state_nx != POP);
            make_pulse <= 1'b0;
            brk_pulse  <= 1'b0;
            if (take) begin
                if (data == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (data == PS2_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    if (brk_pend) begin
                        brk_pulse <= 1'b1;
                        if (same_key) key_held <= 1'b0;
                    end else begin
                        if (!same_key) begin
                            key_count  <= key_count + COUNT_W'(1);
                            make_pulse <= 1'b1;
                        end
                        key_code <= data;
                        key_ext  <= ext_pend;
                        key_held <= 1'b1;
`ifdef PS2_SCAN_ASCII_EN
                        ascii    <= rom_ascii;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)         err_ovf <= 1'b0;
        else if (overflow) err_ovf <= 1'b1;
        else if (clr_err)  err_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb/tb_ps2_scan_ctrl.sv - randomized self-checking bench for ps2_scan_ctrl with a FIFO and key-state model
module tb_ps2_scan_ctrl;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       overflow = 1'b0;
    logic       clr_err = 1'b0;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext, key_held;
    logic [7:0] key_count;
    logic       make_pulse, brk_pulse, err_ovf;
`ifdef PS2_SCAN_ASCII_EN
    logic [7:0] ascii;
`endif

    ps2_scan_ctrl #(.COUNT_W(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .data       (data),
        .overflow   (overflow),
        .clr_err    (clr_err),
        .nextdata_n (nextdata_n),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_held   (key_held),
        .key_count  (key_count),
        .make_pulse (make_pulse),
        .brk_pulse  (brk_pulse),
`ifdef PS2_SCAN_ASCII_EN
        .ascii      (ascii),
`endif
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic       hs[$];
    int         act_makes, act_brks;

    logic [7:0] m_code;
    logic       m_ext, m_held, m_ep, m_bp;
    int         m_count, m_makes, m_brks;

    function automatic void model_reset();
        m_code = 8'h00; m_ext = 1'b0; m_held = 1'b0; m_ep = 1'b0; m_bp = 1'b0;
        m_count = 0; m_makes = 0; m_brks = 0;
    endfunction

    function automatic void push_byte(input logic [7:0] b);
        bit repeat_key;
        q.push_back(b);
        if (b == 8'hE0) m_ep = 1'b1;
        else if (b == 8'hF0) m_bp = 1'b1;
        else begin
            repeat_key = m_held && (b == m_code) && (m_ep == m_ext);
            if (m_bp) begin
                m_brks++;
                if (repeat_key) m_held = 1'b0;
            end else begin
                if (!repeat_key) begin
                    m_count = (m_count + 1) % 256;
                    m_makes++;
                end
                m_code = b; m_ext = m_ep; m_held = 1'b1;
            end
            m_ep = 1'b0; m_bp = 1'b0;
        end
    endfunction

    task automatic clear_counts();
        act_makes = 0; act_brks = 0; m_makes = 0; m_brks = 0;
    endtask

    task automatic fifo_step();
        @(negedge clk);
        if (make_pulse) act_makes++;
        if (brk_pulse)  act_brks++;
        hs.push_back(nextdata_n);
        if (!nextdata_n && q.size() != 0) void'(q.pop_front());
        ready = (q.size() != 0);
        data  = ready ? q[0] : 8'h00;
    endtask

    task automatic run_feed(input int budget);
        int cyc = 0;
        while (q.size() != 0 && cyc < budget) begin
            fifo_step();
            cyc++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL feed_timeout: %0d bytes left, required 0", q.size());
            q.delete();
        end
        repeat (3) fifo_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0; ready = 1'b0; data = 8'h00; q.delete();
        model_reset();
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 7;
        if (nextdata_n !== 1'b1) begin n_fail++; $display("FAIL rst_nextdata_n: got %b want 1", nextdata_n); end
        if (key_code !== 8'h00) begin n_fail++; $display("FAIL rst_key_code: got %h want 00", key_code); end
        if (key_ext !== 1'b0) begin n_fail++; $display("FAIL rst_key_ext: got %b want 0", key_ext); end
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL rst_key_held: got %b want 0", key_held); end
        if (key_count !== 8'h00) begin n_fail++; $display("FAIL rst_key_count: got %h want 00", key_count); end
        if ({make_pulse, brk_pulse} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b want 00", {make_pulse, brk_pulse}); end
        if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_err_ovf: got %b want 0", err_ovf); end
    endtask

    task automatic test_make_break();
        clear_counts();
        push_byte(8'h1C);
        run_feed(20);
        n_checks += 4;
        if (key_code !== 8'h1C) begin n_fail++; $display("FAIL mb_code: got %h want 1c", key_code); end
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL mb_held: got %b want 1", key_held); end
        if (key_count !== 8'd1) begin n_fail++; $display("FAIL mb_count: got %0d want 1", key_count); end
        if (act_makes != 1) begin n_fail++; $display("FAIL mb_makes: got %0d want 1", act_makes); end
        push_byte(8'hF0); push_byte(8'h1C);
        run_feed(30);
        n_checks += 3;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL mb_release: got %b want 0", key_held); end
        if (act_brks != 1) begin n_fail++; $display("FAIL mb_brks: got %0d want 1", act_brks); end
        if (key_count !== 8'd1) begin n_fail++; $display("FAIL mb_count2: got %0d want 1", key_count); end
    endtask

    task automatic test_typematic();
        int c0;
        clear_counts();
        c0 = m_count;
        push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
        run_feed(50);
        n_checks += 3;
        if (key_count !== 8'((c0 + 1) % 256)) begin n_fail++; $display("FAIL typ_count: got %0d want %0d", key_count, (c0 + 1) % 256); end
        if (act_makes != 1) begin n_fail++; $display("FAIL typ_makes: got %0d want 1", act_makes); end
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL typ_held: got %b want 0", key_held); end
    endtask

    task automatic test_extended();
        clear_counts();
        push_byte(8'hE0); push_byte(8'h75);
        run_feed(30);
        n_checks += 3;
        if (key_code !== 8'h75) begin n_fail++; $display("FAIL ext_code: got %h want 75", key_code); end
        if (key_ext !== 1'b1) begin n_fail++; $display("FAIL ext_flag: got %b want 1", key_ext); end
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL ext_held: got %b want 1", key_held); end
        push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
        run_feed(30);
        n_checks++;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL ext_release: got %b want 0", key_held); end
        push_byte(8'h75);
        run_feed(20);
        n_checks += 3;
        if (key_ext !== 1'b0) begin n_fail++; $display("FAIL ext_plain: got %b want 0", key_ext); end
        if (key_count !== 8'(m_count)) begin n_fail++; $display("FAIL ext_count: got %0d want %0d", key_count, m_count); end
        if (act_makes != 2) begin n_fail++; $display("FAIL ext_makes: got %0d want 2", act_makes); end
    endtask

    task automatic test_latency();
        clear_counts();
        @(negedge clk);
        push_byte(8'h4B);
        ready = 1'b1; data = 8'h4B;
        @(negedge clk);
        n_checks++;
        if (key_code !== 8'h4B) begin n_fail++; $display("FAIL latency_code: got %h want 4b", key_code); end
        run_feed(20);
    endtask

    task automatic test_handshake();
        int zeros[$];
        clear_counts();
        hs.delete();
        for (int i = 0; i < 40; i++) push_byte((i % 2) ? 8'h32 : 8'h1C);
        for (int i = 0; i < 30; i++) fifo_step();
        for (int i = 0; i < hs.size(); i++) if (hs[i] === 1'b0) zeros.push_back(i);
        n_checks++;
        if (zeros.size() != 10) begin n_fail++; $display("FAIL hs_pop_count: got %0d want 10", zeros.size()); end
        for (int i = 1; i < zeros.size(); i++) begin
            n_checks++;
            if (zeros[i] - zeros[i-1] != 3) begin
                n_fail++; $display("FAIL hs_spacing: got %0d want 3", zeros[i] - zeros[i-1]);
            end
        end
        run_feed(200);
        n_checks += 2;
        if (key_count !== 8'(m_count)) begin n_fail++; $display("FAIL hs_count: got %0d want %0d", key_count, m_count); end
        if (act_makes != m_makes) begin n_fail++; $display("FAIL hs_makes: got %0d want %0d", act_makes, m_makes); end
    endtask

    task automatic test_reset_mid_pop();
        bit found = 0;
        push_byte(8'h1C); push_byte(8'h32); push_byte(8'h1C);
        for (int i = 0; i < 10 && !found; i++) begin
            fifo_step();
            if (nextdata_n === 1'b0) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rmp_no_pop: got no pop, want pop"); end
        #1 clrn = 1'b0;
        #1;
        n_checks += 4;
        if (nextdata_n !== 1'b1) begin n_fail++; $display("FAIL rmp_nextdata_n: got %b want 1", nextdata_n); end
        if (key_code !== 8'h00) begin n_fail++; $display("FAIL rmp_code: got %h want 00", key_code); end
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL rmp_held: got %b want 0", key_held); end
        if (key_count !== 8'h00) begin n_fail++; $display("FAIL rmp_count: got %h want 00", key_count); end
        q.delete(); ready = 1'b0; data = 8'h00;
        model_reset();
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        clear_counts();
        for (int i = 0; i < 256; i++) push_byte((i % 2) ? 8'h32 : 8'h1C);
        run_feed(256 * 3 + 50);
        n_checks += 2;
        if (key_count !== 8'h00) begin n_fail++; $display("FAIL wrap_count: got %h want 00", key_count); end
        if (act_makes != 256) begin n_fail++; $display("FAIL wrap_makes: got %0d want 256", act_makes); end
    endtask

    task automatic test_overflow();
        @(negedge clk); overflow = 1'b1;
        @(negedge clk); overflow = 1'b0;
        n_checks++;
        if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", err_ovf); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", err_ovf); end
        overflow = 1'b1; clr_err = 1'b1;
        @(negedge clk); overflow = 1'b0; clr_err = 1'b0;
        n_checks++;
        if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", err_ovf); end
        clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        n_checks++;
        if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", err_ovf); end
    endtask

    task automatic test_random();
        logic [7:0] pool [6];
        pool[0] = 8'h1C; pool[1] = 8'h32; pool[2] = 8'h75;
        pool[3] = 8'h5A; pool[4] = 8'hE0; pool[5] = 8'hF0;
        for (int r = 0; r < 6; r++) begin
            clear_counts();
            overflow = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 40; i++) push_byte(pool[$urandom_range(0, 5)]);
            run_feed(40 * 3 + 30);
            overflow = 1'b0;
            n_checks += 6;
            if (key_code !== m_code) begin n_fail++; $display("FAIL rnd_code[%0d]: got %h want %h", r, key_code, m_code); end
            if (key_ext !== m_ext) begin n_fail++; $display("FAIL rnd_ext[%0d]: got %b want %b", r, key_ext, m_ext); end
            if (key_held !== m_held) begin n_fail++; $display("FAIL rnd_held[%0d]: got %b want %b", r, key_held, m_held); end
            if (key_count !== 8'(m_count)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", r, key_count, m_count); end
            if (act_makes != m_makes) begin n_fail++; $display("FAIL rnd_makes[%0d]: got %0d want %0d", r, act_makes, m_makes); end
            if (act_brks != m_brks) begin n_fail++; $display("FAIL rnd_brks[%0d]: got %0d want %0d", r, act_brks, m_brks); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_make_break();
        test_typematic();
        test_extended();
        test_latency();
        test_handshake();
        test_reset_mid_pop();
        test_wrap();
        test_overflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
